// File: rtl/tlul_socket_1n_demux_pkg.sv
// rtl/tlul_socket_1n_demux_pkg.sv - TL-UL channel types, opcodes and defaults shared by the demux slice
package tlul_socket_1n_demux_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_AUW = 8;
  localparam int TL_DUW = 8;

  localparam logic [TL_DUW-1:0] TL_D_USER_DEFAULT = '0;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic [TL_AUW-1:0] a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [TL_DUW-1:0] d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  // Reads expect data back; everything else is acknowledged without data
  function automatic tl_d_op_e tl_ack_opcode(input tl_a_op_e op);
    return (op == Get) ? AccessAckData : AccessAck;
  endfunction

endpackage

// File: rtl/tlul_err_resp.sv
// rtl/tlul_err_resp.sv - one-entry TL-UL device that answers every request with an error
module tlul_err_resp
  import tlul_socket_1n_demux_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_h_i,
  output tl_d2h_t tl_h_o
);

  logic              r_pending;
  logic [TL_AIW-1:0] r_source;
  logic [TL_SZW-1:0] r_size;
  tl_d_op_e          r_opcode;
  logic              w_unused;

  // Only the fields echoed in the response are captured
  assign w_unused = ^{tl_h_i.a_param, tl_h_i.a_address, tl_h_i.a_mask,
                      tl_h_i.a_data, tl_h_i.a_user};

  // Idle accepts one request, Pending holds the error response until the host takes it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending <= 1'b0;
      r_source  <= '0;
      r_size    <= '0;
      r_opcode  <= AccessAck;
    end else if (!r_pending) begin
      if (tl_h_i.a_valid) begin
        r_pending <= 1'b1;
        r_source  <= tl_h_i.a_source;
        r_size    <= tl_h_i.a_size;
        r_opcode  <= tl_ack_opcode(tl_h_i.a_opcode);
      end
    end else if (tl_h_i.d_ready) begin
      r_pending <= 1'b0;
    end
  end

  // Response fields are driven straight from the captured request
  always_comb begin
    tl_h_o          = '0;
    tl_h_o.a_ready  = !r_pending;
    tl_h_o.d_valid  = r_pending;
    tl_h_o.d_opcode = r_opcode;
    tl_h_o.d_param  = '0;
    tl_h_o.d_size   = r_size;
    tl_h_o.d_source = r_source;
    tl_h_o.d_sink   = '0;
    tl_h_o.d_data   = '1;
    tl_h_o.d_user   = TL_D_USER_DEFAULT;
    tl_h_o.d_error  = 1'b1;
  end

endmodule

// File: rtl/tlul_socket_1n_demux.sv
// rtl/tlul_socket_1n_demux.sv - steers one TL-UL host to N devices plus an unmapped-address error responder
module tlul_socket_1n_demux
  import tlul_socket_1n_demux_pkg::*;
#(
  parameter int N              = 4,
  parameter int MaxOutstanding = 8,
  parameter int SelW           = $clog2(N + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  tl_h2d_t         tl_h_i,
  output tl_d2h_t         tl_h_o,
  input  logic [SelW-1:0] dev_select_i,
  output tl_h2d_t         tl_d_o [N],
  input  tl_d2h_t         tl_d_i [N]
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0] r_cnt;
  logic [SelW-1:0] r_cur_sel;

  logic [SelW-1:0] w_sel;
  logic            w_hold;
  logic            w_a_ready;
  logic            w_acc;
  logic            w_rsp;
  tl_d2h_t         w_tgt [N+1];
  tl_h2d_t         w_err_req;
  tl_d2h_t         w_err_rsp;

  // Out-of-range selects all fold onto the error responder
  assign w_sel = (dev_select_i > SelW'(N)) ? SelW'(N) : dev_select_i;

  // Responses must come back in order, so a new target waits until the old one drains
  assign w_hold = ((r_cnt != '0) && (w_sel != r_cur_sel)) ||
                  (r_cnt == CntW'(MaxOutstanding));

  assign w_a_ready = !w_hold && w_tgt[w_sel].a_ready;
  assign w_acc     = tl_h_i.a_valid && w_a_ready;
  assign w_rsp     = tl_h_o.d_valid && tl_h_i.d_ready;

  for (genvar gi = 0; gi < N; gi++) begin : g_dev
    // Device request: host fields pass through, valid/ready gated by selection
    always_comb begin
      tl_d_o[gi]         = tl_h_i;
      tl_d_o[gi].a_valid = tl_h_i.a_valid && (w_sel == SelW'(gi)) && !w_hold;
      tl_d_o[gi].d_ready = tl_h_i.d_ready && (r_cur_sel == SelW'(gi));
    end
    assign w_tgt[gi] = tl_d_i[gi];
  end

  assign w_tgt[N] = w_err_rsp;

  // Error responder sees the request only when the unmapped target is selected
  always_comb begin
    w_err_req         = tl_h_i;
    w_err_req.a_valid = tl_h_i.a_valid && (w_sel == SelW'(N)) && !w_hold;
    w_err_req.d_ready = tl_h_i.d_ready && (r_cur_sel == SelW'(N));
  end

  tlul_err_resp u_err_resp (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tl_h_i (w_err_req),
    .tl_h_o (w_err_rsp)
  );

  // Host response comes from the owning target; nothing is presented with nothing outstanding
  always_comb begin
    tl_h_o         = w_tgt[r_cur_sel];
    tl_h_o.d_valid = w_tgt[r_cur_sel].d_valid && (r_cnt != '0);
    tl_h_o.a_ready = w_a_ready;
  end

  // Outstanding counter and owner of the in-flight requests
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_cur_sel <= '0;
    end else begin
      if (w_acc && !w_rsp && (r_cnt != CntW'(MaxOutstanding))) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_acc && w_rsp && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_acc) begin
        r_cur_sel <= w_sel;
      end
    end
  end

endmodule

// File: tb/tb_tlul_socket_1n_demux.sv
// tb/tb_tlul_socket_1n_demux.sv - directed self-checking bench for the 1:N TL-UL demux
module tb_tlul_socket_1n_demux;
  import tlul_socket_1n_demux_pkg::*;

  localparam int N    = 4;
  localparam int MO   = 8;
  localparam int SelW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  tl_h2d_t         tl_h_i;
  tl_d2h_t         tl_h_o;
  logic [SelW-1:0] dev_sel;
  tl_h2d_t         tl_d_o [N];
  tl_d2h_t         tl_d_i [N];

  int n_chk = 0;
  int n_bad = 0;

  tlul_socket_1n_demux #(.N(N), .MaxOutstanding(MO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tl_h_i       (tl_h_i),
    .tl_h_o       (tl_h_o),
    .dev_select_i (dev_sel),
    .tl_d_o       (tl_d_o),
    .tl_d_i       (tl_d_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] a_valids();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = tl_d_o[i].a_valid;
    return v;
  endfunction

  function automatic logic [N-1:0] d_readys();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = tl_d_o[i].d_ready;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tl_h_i  = '0;
    dev_sel = '0;
    for (int i = 0; i < N; i++) begin
      tl_d_i[i]         = '0;
      tl_d_i[i].a_ready = 1'b1;
    end
  endtask

  task automatic req(input logic [SelW-1:0] sel, input tl_a_op_e op,
                     input logic [7:0] src, input logic [1:0] sz);
    dev_sel           = sel;
    tl_h_i.a_valid    = 1'b1;
    tl_h_i.a_opcode   = op;
    tl_h_i.a_source   = src;
    tl_h_i.a_size     = sz;
    tl_h_i.a_address  = 32'h0000_1000;
    tl_h_i.a_mask     = 4'hF;
    tl_h_i.a_data     = 32'h1234_5678;
  endtask

  task automatic dev_rsp(input int d, input logic v, input tl_d_op_e op,
                         input logic [7:0] src, input logic [31:0] data);
    tl_d_i[d].d_valid  = v;
    tl_d_i[d].d_opcode = op;
    tl_d_i[d].d_source = src;
    tl_d_i[d].d_data   = data;
    tl_d_i[d].d_size   = 2'd2;
  endtask

  initial begin
    idle();
    #1;
    step();
    step();
    rst = 1'b0;
    #1;

    // reset state with idle inputs
    chk("rst_dvalid", tl_h_o.d_valid, 0);
    chk("rst_avalid", a_valids(), 0);
    chk("rst_dready", d_readys(), 0);

    // single Get to device 2
    req(3'd2, Get, 8'h5, 2'd2);
    #1;
    chk("t1_avalid", a_valids(), 4'b0100);
    chk("t1_aready", tl_h_o.a_ready, 1);
    chk("t1_asrc", tl_d_o[2].a_source, 8'h5);
    chk("t1_aaddr", tl_d_o[2].a_address, 32'h0000_1000);
    step();
    tl_h_i.a_valid = 1'b0;
    tl_h_i.d_ready = 1'b1;
    dev_rsp(2, 1'b1, AccessAckData, 8'h5, 32'hCAFE_0001);
    #1;
    chk("t1_dvalid", tl_h_o.d_valid, 1);
    chk("t1_ddata", tl_h_o.d_data, 32'hCAFE_0001);
    chk("t1_dsrc", tl_h_o.d_source, 8'h5);
    chk("t1_dready", d_readys(), 4'b0100);
    step();
    chk("t1_cnt0_stray", tl_h_o.d_valid, 0);
    idle();

    // two Puts to device 1, then a Get to device 3 must wait
    req(3'd1, PutFullData, 8'h1, 2'd2);
    #1;
    chk("t2_put1_aready", tl_h_o.a_ready, 1);
    step();
    tl_h_i.a_source = 8'h2;
    #1;
    chk("t2_put2_aready", tl_h_o.a_ready, 1);
    step();
    req(3'd3, Get, 8'h3, 2'd2);
    #1;
    chk("t2_hold_aready", tl_h_o.a_ready, 0);
    chk("t2_hold_avalid", a_valids(), 0);
    tl_h_i.d_ready = 1'b1;
    dev_rsp(1, 1'b1, AccessAck, 8'h1, 32'h0);
    #1;
    chk("t2_rsp1_dvalid", tl_h_o.d_valid, 1);
    chk("t2_rsp1_aready", tl_h_o.a_ready, 0);
    step();
    dev_rsp(1, 1'b1, AccessAck, 8'h2, 32'h0);
    #1;
    chk("t2_rsp2_aready", tl_h_o.a_ready, 0);
    chk("t2_rsp2_dsrc", tl_h_o.d_source, 8'h2);
    step();
    dev_rsp(1, 1'b0, AccessAck, 8'h0, 32'h0);
    #1;
    chk("t2_rel_aready", tl_h_o.a_ready, 1);
    chk("t2_rel_avalid", a_valids(), 4'b1000);
    step();
    tl_h_i.a_valid = 1'b0;
    dev_rsp(3, 1'b1, AccessAckData, 8'h3, 32'h0BAD_F00D);
    #1;
    chk("t2_dev3_ddata", tl_h_o.d_data, 32'h0BAD_F00D);
    step();
    idle();

    // fill to MaxOutstanding on device 0 which stays silent
    req(3'd0, Get, 8'h10, 2'd2);
    for (int i = 0; i < MO; i++) begin
      #1;
      chk($sformatf("t3_fill%0d", i), tl_h_o.a_ready, 1);
      step();
    end
    chk("t3_full_aready", tl_h_o.a_ready, 0);
    chk("t3_full_avalid", a_valids(), 0);
    tl_h_i.d_ready = 1'b1;
    dev_rsp(0, 1'b1, AccessAckData, 8'h10, 32'h1);
    #1;
    chk("t3_rsp_aready", tl_h_o.a_ready, 0);
    step();
    dev_rsp(0, 1'b0, AccessAckData, 8'h10, 32'h1);
    #1;
    chk("t3_one_more", tl_h_o.a_ready, 1);
    step();
    chk("t3_full_again", tl_h_o.a_ready, 0);
    tl_h_i.a_valid = 1'b0;
    dev_rsp(0, 1'b1, AccessAckData, 8'h10, 32'h1);
    for (int i = 0; i < MO; i++) step();
    chk("t3_drained", tl_h_o.d_valid, 0);
    idle();

    // unmapped Get goes to the error responder
    req(3'd4, Get, 8'h3, 2'd2);
    #1;
    chk("t4_aready", tl_h_o.a_ready, 1);
    chk("t4_no_dev", a_valids(), 0);
    step();
    tl_h_i.a_valid = 1'b0;
    #1;
    chk("t4_dvalid", tl_h_o.d_valid, 1);
    chk("t4_derror", tl_h_o.d_error, 1);
    chk("t4_dop", tl_h_o.d_opcode, AccessAckData);
    chk("t4_ddata", tl_h_o.d_data, 32'hFFFF_FFFF);
    chk("t4_dsrc", tl_h_o.d_source, 8'h3);
    chk("t4_dsize", tl_h_o.d_size, 2'd2);
    req(3'd4, Get, 8'h4, 2'd0);
    #1;
    chk("t4_pend_aready", tl_h_o.a_ready, 0);
    tl_h_i.a_valid = 1'b0;
    step();
    chk("t4_held", tl_h_o.d_valid, 1);
    tl_h_i.d_ready = 1'b1;
    step();
    tl_h_i.d_ready = 1'b0;
    req(3'd6, PutFullData, 8'h7, 2'd1);
    #1;
    chk("t4_put_aready", tl_h_o.a_ready, 1);
    step();
    tl_h_i.a_valid = 1'b0;
    #1;
    chk("t4_put_dop", tl_h_o.d_opcode, AccessAck);
    chk("t4_put_derror", tl_h_o.d_error, 1);
    chk("t4_put_dsrc", tl_h_o.d_source, 8'h7);
    tl_h_i.d_ready = 1'b1;
    step();
    idle();

    // simultaneous accept and response on device 0
    req(3'd0, Get, 8'h20, 2'd2);
    step();
    tl_h_i.a_source = 8'h21;
    tl_h_i.d_ready  = 1'b1;
    dev_rsp(0, 1'b1, AccessAckData, 8'h20, 32'h5);
    #1;
    chk("t5_aready", tl_h_o.a_ready, 1);
    chk("t5_dvalid", tl_h_o.d_valid, 1);
    step();
    tl_h_i.a_valid = 1'b0;
    dev_rsp(0, 1'b1, AccessAckData, 8'h21, 32'h6);
    #1;
    chk("t5_cnt1", tl_h_o.d_valid, 1);
    step();
    chk("t5_cnt0", tl_h_o.d_valid, 0);
    idle();

    // reset with three outstanding to device 1
    req(3'd1, Get, 8'h30, 2'd2);
    step();
    step();
    step();
    tl_h_i.a_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tl_h_i.d_ready = 1'b1;
    dev_rsp(1, 1'b1, AccessAckData, 8'h30, 32'h7);
    #1;
    chk("t6_dvalid", tl_h_o.d_valid, 0);
    chk("t6_dev1_dready", tl_d_o[1].d_ready, 0);
    step();
    chk("t6_dvalid_later", tl_h_o.d_valid, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
